// File: rtl/sdpram_asym_init.sv
// Simple dual-port RAM: narrow byte-masked write port, wide read port.
// Optional post-reset zero-fill; reads are read-first against same-row writes.
module sdpram_asym_init #(
  parameter int WR_DATA_WIDTH = 16,
  parameter int RATIO         = 2,
  parameter int WR_ADDR_WIDTH = 14,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_CLEAR    = 1,
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO,
  localparam int LANE_BITS     = $clog2(RATIO),
  localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH - LANE_BITS,
  localparam int BE_WIDTH      = WR_DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [BE_WIDTH-1:0]      wea,
  input  logic [WR_ADDR_WIDTH-1:0] addra,
  input  logic [WR_DATA_WIDTH-1:0] dina,
  input  logic                     enb,
  input  logic [RD_ADDR_WIDTH-1:0] addrb,
  output logic [RD_DATA_WIDTH-1:0] doutb,
  output logic                     doutb_valid,
  output logic                     init_done
);

  localparam int DEPTH = 1 << RD_ADDR_WIDTH;
  localparam int RD_BE = BE_WIDTH * RATIO;
  localparam int LW    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam logic [RD_ADDR_WIDTH-1:0] LAST_ROW = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [RD_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic init_done_q, init_done_d;
  logic clr_we;
  logic run;

  logic [RD_DATA_WIDTH-1:0] mem [DEPTH];

  logic [RD_ADDR_WIDTH-1:0] wr_row;
  logic [LW-1:0]            wr_lane;
  logic [RD_BE-1:0]         wr_be;
  logic [RD_DATA_WIDTH-1:0] wr_data;

  logic [RD_ADDR_WIDTH-1:0] mem_row;
  logic [RD_BE-1:0]         mem_be;
  logic [RD_DATA_WIDTH-1:0] mem_wdata;

  logic                     rd_fire;
  logic                     s1_vld_q;
  logic [RD_DATA_WIDTH-1:0] s1_data_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state: clr_cnt parks on the last row instead of wrapping
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        if (clr_cnt_q == LAST_ROW) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      (state_q == ST_RUN): begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Outputs
  always_comb begin
    clr_we      = (state_q == ST_CLEAR);
    run         = (state_q == ST_RUN);
    init_done_d = (state_d == ST_RUN);
  end

  assign init_done = init_done_q;

  // Lane 0 of a wide row holds the lowest narrow address
  if (RATIO == 1) begin : g_lane1
    assign wr_lane = '0;
  end else begin : g_laneN
    assign wr_lane = addra[LANE_BITS-1:0];
  end

  always_comb begin
    wr_row  = addra[WR_ADDR_WIDTH-1:LANE_BITS];
    wr_be   = RD_BE'(wea) << (wr_lane * BE_WIDTH);
    wr_data = {RATIO{dina}};
  end

  always_comb begin
    mem_row   = wr_row;
    mem_be    = (ena && run) ? wr_be : '0;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_row   = clr_cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < RD_BE; b++) begin
      if (mem_be[b]) begin
        mem[mem_row][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Read port: non-blocking update makes a same-row write read-first
  assign rd_fire = enb & run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= rd_fire;
      if (rd_fire) begin
        s1_data_q <= mem[addrb];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                     s2_vld_q;
    logic [RD_DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign doutb       = s2_data_q;
    assign doutb_valid = s2_vld_q;
  end else begin : g_lat1
    assign doutb       = s1_data_q;
    assign doutb_valid = s1_vld_q;
  end

endmodule

// File: tb/tb_sdpram_asym_init.sv
// Directed bench: default config (clear, latency 1) and a
// latency-2 / ratio-4 / no-clear instance sharing one clock.
module tb_sdpram_asym_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst_n, a_ena, a_enb, a_vld, a_done;
  logic [1:0]  a_wea;
  logic [13:0] a_addra;
  logic [15:0] a_dina;
  logic [12:0] a_addrb;
  logic [31:0] a_doutb;

  logic        b_rst_n, b_ena, b_enb, b_vld, b_done;
  logic [1:0]  b_wea;
  logic [13:0] b_addra;
  logic [15:0] b_dina;
  logic [11:0] b_addrb;
  logic [63:0] b_doutb;

  sdpram_asym_init u_a (
    .clk(clk), .rst_n(a_rst_n), .ena(a_ena), .wea(a_wea),
    .addra(a_addra), .dina(a_dina), .enb(a_enb), .addrb(a_addrb),
    .doutb(a_doutb), .doutb_valid(a_vld), .init_done(a_done)
  );

  sdpram_asym_init #(
    .RATIO(4), .READ_LATENCY(2), .INIT_CLEAR(0)
  ) u_b (
    .clk(clk), .rst_n(b_rst_n), .ena(b_ena), .wea(b_wea),
    .addra(b_addra), .dina(b_dina), .enb(b_enb), .addrb(b_addrb),
    .doutb(b_doutb), .doutb_valid(b_vld), .init_done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [13:0] ad, input logic [15:0] d,
                      input logic [1:0] we);
    a_ena = 1'b1; a_addra = ad; a_dina = d; a_wea = we;
    tick();
    a_ena = 1'b0; a_wea = 2'b00;
  endtask

  task automatic rd_a(input logic [12:0] row);
    a_enb = 1'b1; a_addrb = row;
    tick();
    a_enb = 1'b0;
  endtask

  logic [63:0] row0, row1, row2;
  int  cyc;
  bit  seen_v;

  initial begin
    a_rst_n = 1'b0; a_ena = 1'b0; a_enb = 1'b0; a_wea = 2'b00;
    a_addra = '0; a_dina = '0; a_addrb = '0;
    b_rst_n = 1'b0; b_ena = 1'b0; b_enb = 1'b0; b_wea = 2'b00;
    b_addra = '0; b_dina = '0; b_addrb = '0;
    row0 = 64'hA003_A002_A001_A000;
    row1 = 64'hA007_A006_A005_A004;
    row2 = 64'hA00B_A00A_A009_A008;

    tick(); tick();
    chk("a_rst_dout", 64'(a_doutb), 64'h0);
    chk("a_rst_vld", 64'(a_vld), 64'h0);
    chk("a_rst_done", 64'(a_done), 64'h0);

    // Clear phase with write/read attempts that must be ignored
    a_rst_n = 1'b1;
    a_ena = 1'b1; a_addra = 14'd5; a_dina = 16'hBEEF; a_wea = 2'b11;
    a_enb = 1'b1; a_addrb = 13'd2;
    cyc = 0;
    seen_v = 1'b0;
    while (!a_done && cyc < 9000) begin
      tick();
      cyc++;
      if (a_vld) seen_v = 1'b1;
    end
    a_ena = 1'b0; a_enb = 1'b0; a_wea = 2'b00;
    chk("clr_len", 64'(cyc), 64'd8192);
    chk("clr_no_vld", 64'(seen_v), 64'h0);

    rd_a(13'h1FFF);
    chk("last_row_vld", 64'(a_vld), 64'h1);
    chk("last_row_dat", 64'(a_doutb), 64'h0);
    rd_a(13'd2);
    chk("row2_vld", 64'(a_vld), 64'h1);
    chk("row2_zero", 64'(a_doutb), 64'h0);

    wr_a(14'd6, 16'h1234, 2'b11);
    wr_a(14'd7, 16'hABCD, 2'b11);
    rd_a(13'd3);
    chk("row3_vld", 64'(a_vld), 64'h1);
    chk("row3_dat", 64'(a_doutb), 64'hABCD1234);
    tick();
    chk("vld_1cyc", 64'(a_vld), 64'h0);
    chk("dout_hold", 64'(a_doutb), 64'hABCD1234);

    wr_a(14'd6, 16'hFF00, 2'b10);
    rd_a(13'd3);
    chk("byte_en", 64'(a_doutb), 64'hABCDFF34);

    // Same-row write and read in one cycle
    a_ena = 1'b1; a_addra = 14'd7; a_dina = 16'h5555; a_wea = 2'b11;
    a_enb = 1'b1; a_addrb = 13'd3;
    tick();
    a_ena = 1'b0; a_enb = 1'b0; a_wea = 2'b00;
    chk("coll_vld", 64'(a_vld), 64'h1);
    chk("coll_old", 64'(a_doutb), 64'hABCDFF34);
    rd_a(13'd3);
    chk("coll_new", 64'(a_doutb), 64'h5555FF34);

    wr_a(14'd6, 16'h0000, 2'b00);
    rd_a(13'd3);
    chk("wea0_noop", 64'(a_doutb), 64'h5555FF34);

    // Back-to-back reads on the latency-1 port
    a_enb = 1'b1; a_addrb = 13'd2;
    tick();
    chk("b2b_a0", 64'(a_doutb), 64'h0);
    a_addrb = 13'd3;
    tick();
    a_enb = 1'b0;
    chk("b2b_a1_vld", 64'(a_vld), 64'h1);
    chk("b2b_a1", 64'(a_doutb), 64'h5555FF34);

    // Latency 2, ratio 4, no clear
    chk("b_rst_done", 64'(b_done), 64'h0);
    b_rst_n = 1'b1;
    tick();
    chk("b_done_1cyc", 64'(b_done), 64'h1);
    for (int i = 0; i < 12; i++) begin
      b_ena = 1'b1; b_wea = 2'b11;
      b_addra = 14'(i);
      b_dina = 16'(16'hA000 + i);
      tick();
    end
    b_ena = 1'b0; b_wea = 2'b00;

    b_enb = 1'b1; b_addrb = 12'd0;
    tick();
    chk("b_lat_not1", 64'(b_vld), 64'h0);
    b_addrb = 12'd1;
    tick();
    chk("b_r0_vld", 64'(b_vld), 64'h1);
    chk("b_r0_dat", b_doutb, row0);
    b_addrb = 12'd2;
    tick();
    b_enb = 1'b0;
    chk("b_r1_vld", 64'(b_vld), 64'h1);
    chk("b_r1_dat", b_doutb, row1);

    // Third read is still in flight here
    b_rst_n = 1'b0;
    #1;
    chk("b_rst_dout", b_doutb, 64'h0);
    chk("b_rst_vld", 64'(b_vld), 64'h0);
    tick();
    tick();
    chk("b_rst_vld2", 64'(b_vld), 64'h0);
    chk("b_rst_done", 64'(b_done), 64'h0);
    b_rst_n = 1'b1;
    tick();
    chk("b_r2_dropped", 64'(b_vld), 64'h0);
    chk("b_done_again", 64'(b_done), 64'h1);
    tick();
    chk("b_r2_dropped2", 64'(b_vld), 64'h0);
    chk("b_dout_zero", b_doutb, 64'h0);

    b_enb = 1'b1; b_addrb = 12'd2;
    tick();
    b_enb = 1'b0;
    tick();
    chk("b_r2_vld", 64'(b_vld), 64'h1);
    chk("b_r2_dat", b_doutb, row2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdpram_asym_init.md
Name: sdpram_asym_init

Overview:
- Parametrised simple dual-port RAM for NVMe controller data buffering.
- Narrow write port, wide read port, integer power-of-two width ratio, per-byte write enables, selectable read latency with a valid strobe.
- Optional post-reset hardware clear sequencer so software and DMA never read stale buffer contents.
- Single clock domain; sits between the PCIe-side write datapath and the wider internal read datapath.

Parameters:
- WR_DATA_WIDTH, 16: write port width in bits; multiple of 8.
- RATIO, 2: read width / write width; legal values 1, 2, 4, 8.
- WR_ADDR_WIDTH, 14: write address width; narrow depth = 2^WR_ADDR_WIDTH.
- READ_LATENCY, 1: enb-to-doutb cycles; legal values 1 or 2.
- INIT_CLEAR, 1: 1 = zero the whole array after reset; 0 = no clear.
- Derived, not overridable:
  - RD_DATA_WIDTH = WR_DATA_WIDTH*RATIO
  - RD_ADDR_WIDTH = WR_ADDR_WIDTH - log2(RATIO)
  - BE_WIDTH = WR_DATA_WIDTH/8

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  write enable.
- wea  input  BE_WIDTH  per-byte write enables, qualified by ena.
- addra  input  WR_ADDR_WIDTH  narrow write address.
- dina  input  WR_DATA_WIDTH  write data.
- enb  input  1  read enable.
- addrb  input  RD_ADDR_WIDTH  wide read address.
- doutb  output  RD_DATA_WIDTH  read data.
- doutb_valid  output  1  one-cycle strobe marking new doutb.
- init_done  output  1  high when the array is usable.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: doutb = 0, doutb_valid = 0, init_done = 0, all read pipeline stages invalid, clear counter = 0.
- Array contents are not reset by rst_n, only by the clear sequence.
- Lane mapping: wide row r, lane k (bits k*WR_DATA_WIDTH +: WR_DATA_WIDTH) is narrow address r*RATIO+k, so lane 0 holds the lowest narrow address.
- Write: when ena=1 in RUN, byte j of narrow word addra is updated from dina byte j iff wea[j]=1. ena=1 with wea=0 is a no-op.
- Read: enb=1 in RUN at cycle t gives doutb and doutb_valid=1 at edge t+READ_LATENCY.
- With enb low, doutb holds its last value and doutb_valid=0.
- Back-to-back reads give one result per cycle.
- Collision: a write and a read touching the same row in the same cycle is read-first; doutb returns pre-write data, and the write lands normally.
- FSM states:
  - CLEAR: entered on reset when INIT_CLEAR=1. Each cycle writes all-zero to wide row clr_cnt, then clr_cnt++. ena and enb are ignored (no write, no valid). After row 2^RD_ADDR_WIDTH-1, go to RUN.
  - RUN: entered on reset when INIT_CLEAR=0. init_done=1 registered, asserted the first cycle in RUN. Stays in RUN until reset.
- Clear duration: exactly 2^RD_ADDR_WIDTH cycles after rst_n deasserts. With defaults that is 8192; init_done rises at edge 8192.
- Reset mid-operation (either state): in-flight reads are dropped with no valid, doutb forced to 0, and the FSM restarts CLEAR from row 0. A partial clear is never reported done.
- Address wrap: none; every address is in range by width, and clr_cnt terminates at the max row without wrapping.

Test Plan:
- Defaults. Release rst_n and count cycles. Required: init_done=0 for 8192 cycles, then 1. Reading row 0x1FFF gives doutb=0x00000000 with valid.
- During CLEAR, drive ena=1, addra=5, dina=0xBEEF and enb=1. Required: doutb_valid stays 0; after init_done, reading row 2 gives 0x00000000.
- Write addra=0x0006 dina=0x1234, then addra=0x0007 dina=0xABCD, both wea=2'b11. Read addrb=3. Required: doutb=0xABCD1234 one cycle later, doutb_valid high for exactly 1 cycle.
- Byte enable: row 3 holds 0xABCD1234. Write addra=6, dina=0xFF00, wea=2'b10. Read addrb=3. Required: 0xABCDFF34.
- Collision: row 3 holds 0xABCDFF34. In the same cycle write addra=7 dina=0x5555 wea=11 and read addrb=3. Required: 0xABCDFF34. The next read returns 0x5555FF34.
- READ_LATENCY=2, RATIO=4, INIT_CLEAR=0. Issue 3 back-to-back reads, then assert rst_n=0 while read 3 is in flight. Required: valid at t+2 and t+3 only; read 3 produces no valid; doutb=0; init_done=1 one cycle after release.
